// File: rtl/adc_share_arbiter.sv
// adc_share_arbiter: lets two clients share one ADC. Requests are granted
// round-robin. The arbiter drives the ADC four-phase req/rdy handshake and
// returns each sample only to the client that was granted. If the ADC does
// not answer within TIMEOUT cycles, the request is dropped and err pulses.
// Build option: define ADC_ARB_FIXED_PRI_EN so that client 0 always wins
// when both clients request at once.
module adc_share_arbiter #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adc_rdy,
    input  logic [DATA_W-1:0] adc_dat,
    output logic              adc_req,
    input  logic              c0_req,
    output logic              c0_rdy,
    output logic [DATA_W-1:0] c0_dat,
    input  logic              c1_req,
    output logic              c1_rdy,
    output logic [DATA_W-1:0] c1_dat,
    output logic              err,
    output logic              err_id,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam int          CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_q,   state_d;
    logic                grant_q,   grant_d;
    logic                ptr_q,     ptr_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic                adc_req_q, adc_req_d;
    logic                c0_rdy_q,  c0_rdy_d;
    logic                c1_rdy_q,  c1_rdy_d;
    logic [DATA_W-1:0]   c0_dat_q,  c0_dat_d;
    logic [DATA_W-1:0]   c1_dat_q,  c1_dat_d;
    logic                err_q,     err_d;
    logic                err_id_q,  err_id_d;

    // Decide which client wins. Call only when at least one client requests.
    function automatic logic pick_client(input logic r0, input logic r1, input logic ptr);
`ifdef ADC_ARB_FIXED_PRI_EN
        return ~r0 | (r1 & ptr & 1'b0);
`else
        if (r0 && r1)
            return ptr;
        return r1;
`endif
    endfunction

    // Next-state logic and output decode; every signal gets its default value first.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        adc_req_d = adc_req_q;
        c0_rdy_d  = 1'b0;
        c1_rdy_d  = 1'b0;
        c0_dat_d  = c0_dat_q;
        c1_dat_d  = c1_dat_q;
        err_d     = 1'b0;
        err_id_d  = err_id_q;

        case (state_q)
            S_IDLE: begin
                // adc_rdy seen here is spurious and is ignored.
                cnt_d = '0;
                if (c0_req || c1_req) begin
                    grant_d   = pick_client(c0_req, c1_req, ptr_q);
                    adc_req_d = 1'b1;
                    state_d   = S_REQ;
                end
            end

            S_REQ: begin
                adc_req_d = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                // A sample that arrives on the last allowed cycle wins over the timeout.
                if (adc_rdy) begin
                    if (grant_q) begin
                        c1_dat_d = adc_dat;
                        c1_rdy_d = 1'b1;
                    end else begin
                        c0_dat_d = adc_dat;
                        c0_rdy_d = 1'b1;
                    end
                    adc_req_d = 1'b0;
                    ptr_d     = ~grant_q;
                    state_d   = S_RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    adc_req_d = 1'b0;
                    err_d     = 1'b1;
                    err_id_d  = grant_q;
                    ptr_d     = ~grant_q;
                    state_d   = S_RELEASE;
                end
            end

            S_RELEASE: begin
                // The handshake is complete once the ADC lowers rdy.
                adc_req_d = 1'b0;
                if (!adc_rdy)
                    state_d = S_IDLE;
            end

            default: begin
                adc_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and output registers. Reset also drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            grant_q   <= 1'b0;
            ptr_q     <= 1'b0;
            cnt_q     <= '0;
            adc_req_q <= 1'b0;
            c0_rdy_q  <= 1'b0;
            c1_rdy_q  <= 1'b0;
            c0_dat_q  <= '0;
            c1_dat_q  <= '0;
            err_q     <= 1'b0;
            err_id_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            adc_req_q <= adc_req_d;
            c0_rdy_q  <= c0_rdy_d;
            c1_rdy_q  <= c1_rdy_d;
            c0_dat_q  <= c0_dat_d;
            c1_dat_q  <= c1_dat_d;
            err_q     <= err_d;
            err_id_q  <= err_id_d;
        end
    end

    assign adc_req = adc_req_q;
    assign c0_rdy  = c0_rdy_q;
    assign c1_rdy  = c1_rdy_q;
    assign c0_dat  = c0_dat_q;
    assign c1_dat  = c1_dat_q;
    assign err     = err_q;
    assign err_id  = err_id_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: doc/adc_share_arbiter.md
Name: adc_share_arbiter

Overview:
- Round-robin arbiter that shares one 8-bit ADC between two requesters, e.g. the transient-capture controller (client 0) and a slow level monitor (client 1).
- Sits between the clients and the ADC.
- Runs the ADC four-phase req/rdy handshake and returns each sample only to the client that was granted.
- Aborts with an error pulse if the ADC fails to answer within a timeout.

Parameters:
- DATA_W, 8, ADC sample width.
- TIMEOUT, 64, maximum cycles adc_req may stay high without adc_rdy; range 2..65535.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- adc_rdy  input  1  ADC sample-valid, four-phase handshake.
- adc_dat  input  DATA_W  ADC sample; valid while adc_rdy=1.
- adc_req  output  1  conversion request to the ADC.
- c0_req  input  1  client 0 request (level).
- c0_rdy  output  1  one-cycle pulse: c0_dat valid.
- c0_dat  output  DATA_W  sample returned to client 0.
- c1_req  input  1  client 1 request (level).
- c1_rdy  output  1  one-cycle pulse: c1_dat valid.
- c1_dat  output  DATA_W  sample returned to client 1.
- err  output  1  one-cycle pulse on timeout abort.
- err_id  output  1  client that was granted at the last timeout.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values: adc_req=0, c0_rdy=0, c1_rdy=0, c0_dat=0, c1_dat=0, err=0, err_id=0, busy=0. State=IDLE, grant=0, priority pointer=0 (client 0 favoured), timeout counter=0.
- Reset asserted in any state returns to these values on the next edge. A transaction in flight is dropped and no rdy pulse is issued.
- State IDLE:
  - If any cN_req=1, grant the pointer-favoured requester, or the only requester. Go to REQ.
  - Set adc_req=1 and busy=1 on the same edge; adc_req is visible the cycle after the request is sampled.
  - Clear the timeout counter.
- State REQ:
  - adc_req held 1; the counter increments each cycle.
  - adc_rdy=1 sampled: latch adc_dat into the granted cN_dat, pulse the granted cN_rdy for exactly one cycle, drop adc_req, go to RELEASE.
  - Counter reaches TIMEOUT-1 with adc_rdy still 0: drop adc_req, pulse err, set err_id=grant, go to RELEASE. The granted cN_dat is unchanged.
  - adc_rdy takes precedence if both conditions occur on the same edge.
- State RELEASE:
  - Wait for adc_rdy=0, which ends the four-phase handshake. Then go to IDLE.
  - Flip the pointer to favour the non-granted client.
  - Pointer also flips after a timeout.
- Latency: a request sampled in IDLE with the ADC answering on its first REQ cycle gives cN_rdy two edges after the request. Minimum gap between consecutive grants is 4 cycles.
- Non-granted client data and rdy never change.
- A client still requesting after its rdy pulse is a new request, arbitrated normally. With both requesting continuously, grants strictly alternate 0,1,0,1.
- Requests dropped while in REQ or RELEASE do not cancel the transaction; the sample is still delivered.
- adc_rdy=1 seen in IDLE is ignored (spurious).
- adc_dat is sampled only on the capture edge; no width conversion.

Optional Feature:
- Macro: ADC_ARB_FIXED_PRI_EN.
- Defined: the pointer is ignored and client 0 always wins simultaneous requests. Client 1 is granted only when c0_req=0 in IDLE.
- Undefined: round-robin as above.

Test Plan:
1. Reset, then c0_req=1 held. ADC model answers adc_rdy=1 with adc_dat=8'hD6 one cycle after adc_req rises, and drops rdy once req falls. Required: c0_dat=8'hD6, one-cycle c0_rdy pulse, c1_rdy never high, busy returns to 0.
2. c0_req and c1_req both held high; ADC returns 8'h10, 8'h20, 8'h30, 8'h40 in order. Required: grants alternate 0,1,0,1; c0_dat takes 8'h10 then 8'h30; c1_dat takes 8'h20 then 8'h40.
3. c1_req=1, ADC never answers, TIMEOUT=64. Required: adc_req high for exactly 64 cycles, then low; err pulses once with err_id=1; c1_rdy stays 0; c1_dat unchanged; next grant favours client 0.
4. Reset asserted for one cycle while in REQ. Required: the next edge shows adc_req=0 and busy=0, no rdy pulse, and the pointer is back to 0.
5. Spurious adc_rdy=1 pulse in IDLE with no requests. Required: no outputs change.
6. With ADC_ARB_FIXED_PRI_EN defined, both clients held high for 3 transactions. Required: all three grants go to client 0 and c1_rdy stays 0.
